// File: rtl/ioctl_word_loader.sv
// Packs the data_io byte stream into little-endian words, buffers them in a FIFO and
// releases them in bursts to a word-oriented consumer, with per-target loaded flags.
module ioctl_word_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int BUF_DEPTH   = 64,
  parameter int NUM_TARGETS = 4,
  parameter int INDEX_BASE  = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [NUM_TARGETS-1:0] ld_target,
  output logic                   ld_wr,
  input  logic                   ld_req,
  output logic [DATA_W-1:0]      ld_din,
  output logic [ADDR_W-1:0]      ld_addr,
  output logic                   busy,
  output logic [NUM_TARGETS-1:0] loaded,
  output logic                   overflow
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] HALF_LVL = (PTR_W+1)'(BUF_DEPTH / 2);
  localparam logic [PTR_W:0] WAIT_LVL = (PTR_W+1)'(BUF_DEPTH - 2);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic                   dl_d, pend_start;
  logic [DATA_W-1:0]      asm_q, asm_wr, push_word;
  logic                   part_q, push_q, burst_q;
  logic [PTR_W-1:0]       wptr, rptr;
  logic [PTR_W:0]         count;
  logic [DATA_W-1:0]      mem [BUF_DEPTH];
  logic [LANE_W-1:0]      lane;
  logic                   last_lane, rise, fall, start, pop, full, do_push;
  logic                   tgt_ok, unused_addr;
  int                     tgt_i;
  logic [NUM_TARGETS-1:0] tgt_onehot;

  always_comb begin
    tgt_i  = int'(ioctl_index) - INDEX_BASE;
    tgt_ok = (tgt_i >= 0) && (tgt_i < NUM_TARGETS);
    tgt_onehot = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++)
      tgt_onehot[i] = tgt_ok && (tgt_i == int'(i));
  end

  always_comb begin
    unused_addr = ^ioctl_addr;
    lane        = ioctl_addr[LANE_W-1:0];
    last_lane   = (int'(lane) == BYTES - 1);
    asm_wr      = asm_q;
    for (int unsigned i = 0; i < BYTES; i++)
      if (int'(lane) == int'(i)) asm_wr[i*8 +: 8] = ioctl_dout;
  end

  always_comb begin
    rise    = ioctl_download & ~dl_d;
    fall    = ~ioctl_download & dl_d;
    // a rising edge seen during FLUSH/DONE is held in pend_start until IDLE
    start   = (state == IDLE) & ioctl_download & (~dl_d | pend_start) & tgt_ok;
    full    = (count == FULL_LVL);
    do_push = push_q & ~full;
    case (state)
      FILL:    ld_wr = (count >= HALF_LVL) | (burst_q & (count != '0));
      FLUSH:   ld_wr = (count != '0);
      default: ld_wr = 1'b0;
    endcase
    pop        = ld_req & ld_wr;
    ld_din     = ld_wr ? mem[rptr] : '0;
    ioctl_wait = (state == FILL) && (count >= WAIT_LVL);
    busy       = (state != IDLE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FILL;
      FILL:    if (fall) state_nx = FLUSH;
      FLUSH:   if ((count == '0) && !push_q && !part_q) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_d       <= 1'b0;
      pend_start <= 1'b0;
      asm_q      <= '0;
      push_word  <= '0;
      part_q     <= 1'b0;
      push_q     <= 1'b0;
      burst_q    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ld_addr    <= '0;
      ld_target  <= '0;
      loaded     <= '0;
      overflow   <= 1'b0;
    end else begin
      dl_d       <= ioctl_download;
      pend_start <= (pend_start | (rise & (state == FLUSH || state == DONE)))
                    & ioctl_download & ~start;
      push_q     <= 1'b0;
      burst_q    <= (state == FILL) & ld_wr;
      if (push_q && full) overflow <= 1'b1;
      if (do_push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        ld_addr <= ld_addr + 1'b1;
      end
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
      case (state)
        IDLE: if (start) begin
          ld_target <= tgt_onehot;
          loaded    <= loaded & ~tgt_onehot;
          overflow  <= 1'b0;
          ld_addr   <= '0;
          wptr      <= '0;
          rptr      <= '0;
          count     <= '0;
          asm_q     <= '0;
          part_q    <= 1'b0;
        end
        FILL: if (ioctl_wr) begin
          if (last_lane) begin
            push_word <= asm_wr;
            push_q    <= 1'b1;
            asm_q     <= '0;
            part_q    <= 1'b0;
          end else begin
            asm_q  <= asm_wr;
            part_q <= 1'b1;
          end
        end
        FLUSH: if (part_q) begin
          push_word <= asm_q;
          push_q    <= 1'b1;
          asm_q     <= '0;
          part_q    <= 1'b0;
        end
        default: begin
          loaded    <= loaded | ld_target;
          ld_target <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wptr] <= push_word;
  end

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Randomised bench for ioctl_word_loader: queue-based reference model checked every
// cycle, plus literal expectations for the directed loads.
module tb_ioctl_word_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 64;
  localparam int NT     = 4;
  localparam int BYTES  = DATA_W / 8;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = '0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              ioctl_wait;
  logic [NT-1:0]     ld_target;
  logic              ld_wr;
  logic              ld_req = 1'b0;
  logic [DATA_W-1:0] ld_din;
  logic [ADDR_W-1:0] ld_addr;
  logic              busy;
  logic [NT-1:0]     loaded;
  logic              overflow;

  ioctl_word_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(DEPTH),
                      .NUM_TARGETS(NT), .INDEX_BASE(0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ld_target(ld_target),
    .ld_wr(ld_wr), .ld_req(ld_req), .ld_din(ld_din), .ld_addr(ld_addr),
    .busy(busy), .loaded(loaded), .overflow(overflow));

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_FILL, P_FLUSH, P_DONE} phase_t;
  phase_t            ph;
  logic [DATA_W-1:0] q[$];
  logic [ADDR_W-1:0] m_addr;
  logic              pend, part, burst, dl_prev, defer, m_ovf;
  logic [DATA_W-1:0] pend_word;
  logic [7:0]        asmb[BYTES];
  int                tgt;
  logic [NT-1:0]     m_loaded;
  logic [DATA_W-1:0] log_d[$];
  int                log_a[$];

  // scratch for the compare process
  int                sz, ti, lane;
  logic              e_wr, popm, risem, fallm, okm, startm, pend_old, part_old;
  logic [DATA_W-1:0] e_din;
  logic [NT-1:0]     e_tgt;

  function automatic logic [DATA_W-1:0] pack_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < BYTES; i++) w[i*8 +: 8] = asmb[i];
    return w;
  endfunction

  task automatic clear_asm();
    for (int i = 0; i < BYTES; i++) asmb[i] = 8'h00;
    part = 1'b0;
  endtask

  task automatic model_reset();
    ph = P_IDLE; q.delete(); m_addr = '0; pend = 0; pend_word = '0; burst = 0;
    dl_prev = 0; defer = 0; m_ovf = 0; tgt = 0; m_loaded = '0;
    clear_asm();
  endtask

  initial model_reset();

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      model_reset();
      chk("rst_ld_wr", ld_wr, 0);       chk("rst_busy", busy, 0);
      chk("rst_ld_target", ld_target, 0); chk("rst_loaded", loaded, 0);
      chk("rst_overflow", overflow, 0); chk("rst_ioctl_wait", ioctl_wait, 0);
      chk("rst_ld_din", ld_din, 0);     chk("rst_ld_addr", ld_addr, 0);
    end else begin
      sz = q.size();
      if (ph == P_FILL)       e_wr = (sz >= DEPTH/2) || (burst && sz > 0);
      else if (ph == P_FLUSH) e_wr = (sz > 0);
      else                    e_wr = 1'b0;
      e_din = e_wr ? q[0] : '0;
      e_tgt = (ph != P_IDLE) ? NT'(1 << tgt) : '0;
      chk("ld_wr", ld_wr, e_wr);
      chk("ld_din", ld_din, e_din);
      chk("ld_addr", ld_addr, m_addr);
      chk("ioctl_wait", ioctl_wait, (ph == P_FILL) && (sz >= DEPTH-2));
      chk("busy", busy, ph != P_IDLE);
      chk("ld_target", ld_target, e_tgt);
      chk("loaded", loaded, m_loaded);
      chk("overflow", overflow, m_ovf);
      if (ld_wr && ld_req) begin
        log_d.push_back(ld_din);
        log_a.push_back(int'(ld_addr));
      end
      // advance the model across the coming clock edge
      popm   = ld_req && e_wr;
      risem  = ioctl_download && !dl_prev;
      fallm  = !ioctl_download && dl_prev;
      ti     = int'(ioctl_index);
      okm    = (ti >= 0) && (ti < NT);
      startm = (ph == P_IDLE) && ioctl_download && (risem || defer) && okm;
      pend_old = pend;
      part_old = part;
      if (popm) begin
        void'(q.pop_front());
        m_addr = m_addr + 1'b1;
      end
      if (pend_old) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else q.push_back(pend_word);
      end
      pend  = 1'b0;
      burst = (ph == P_FILL) && e_wr;
      defer = (defer || (risem && (ph == P_FLUSH || ph == P_DONE))) && ioctl_download && !startm;
      case (ph)
        P_IDLE: if (startm) begin
          ph = P_FILL; tgt = ti; m_loaded[ti] = 1'b0; m_ovf = 1'b0;
          q.delete(); m_addr = '0; clear_asm();
        end
        P_FILL: begin
          if (ioctl_wr) begin
            lane = int'(ioctl_addr % BYTES);
            asmb[lane] = ioctl_dout;
            if (lane == BYTES-1) begin
              pend = 1'b1; pend_word = pack_word(); clear_asm();
            end else part = 1'b1;
          end
          if (fallm) ph = P_FLUSH;
        end
        P_FLUSH: begin
          if (part_old) begin
            pend = 1'b1; pend_word = pack_word(); clear_asm();
          end else if (sz == 0 && !pend_old) ph = P_DONE;
        end
        default: begin
          m_loaded = m_loaded | NT'(1 << tgt);
          ph = P_IDLE;
        end
      endcase
      dl_prev = ioctl_download;
    end
  end

  // ---------------- stimulus ----------------
  int         req_mode = 0;
  logic [7:0] bbuf[$];

  initial forever begin
    @(posedge clk_sys); #1;
    if (req_mode == 1)      ld_req = 1'b1;
    else if (req_mode == 2) ld_req = 1'($urandom_range(0, 1));
    else                    ld_req = 1'b0;
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic send(input int first, input int last, input bit honour, input int maxgap);
    int w;
    for (int i = first; i <= last; i++) begin
      w = 0;
      while (honour && ioctl_wait && w < 3000) begin tick(); w++; end
      if (w >= 3000) chk("wait_timeout", ioctl_wait, 0);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = bbuf[i];
      tick();
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1; tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0; tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  function automatic logic [DATA_W-1:0] logd(input int i);
    return (i < log_d.size()) ? log_d[i] : 16'hDEAD;
  endfunction

  function automatic int loga(input int i);
    return (i < log_a.size()) ? log_a[i] : -1;
  endfunction

  task automatic fill_seq(input int n);
    bbuf.delete();
    for (int i = 0; i < n; i++) bbuf.push_back(8'(i));
  endtask

  initial begin
    int n;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("t1_busy", busy, 0); chk("t1_ld_wr", ld_wr, 0); chk("t1_loaded", loaded, 0);
    chk("t1_overflow", overflow, 0); chk("t1_ld_addr", ld_addr, 0);

    // 128 sequential bytes, consumer always ready
    req_mode = 1; log_d.delete(); log_a.delete(); fill_seq(128);
    start_dl(8'd0); send(0, 127, 1, 0); end_dl(); wait_idle();
    chk("t2_nwords", log_d.size(), 64); chk("t2_w0", logd(0), 16'h0100);
    chk("t2_w63", logd(63), 16'h7F7E); chk("t2_a63", loga(63), 63);
    chk("t2_loaded", loaded, 4'b0001); chk("t2_overflow", overflow, 0);

    // partial final word is zero-padded
    log_d.delete(); log_a.delete();
    bbuf.delete(); bbuf = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    start_dl(8'd0); send(0, 4, 1, 1); end_dl(); wait_idle();
    chk("t3_nwords", log_d.size(), 3); chk("t3_w0", logd(0), 16'hBBAA);
    chk("t3_w1", logd(1), 16'hDDCC); chk("t3_w2", logd(2), 16'h00EE);
    chk("t3_a2", loga(2), 2);

    // backpressure with a stalled consumer
    req_mode = 0; fill_seq(200);
    start_dl(8'd1); send(0, 123, 1, 0); repeat (2) tick();
    chk("t4_wait", ioctl_wait, 1); chk("t4_ld_wr", ld_wr, 1); chk("t4_ovf", overflow, 0);
    req_mode = 2; send(124, 199, 1, 0); end_dl(); wait_idle();
    chk("t4_loaded", loaded, 4'b0011); chk("t4_ovf_end", overflow, 0);

    // ignoring backpressure overflows the FIFO
    req_mode = 0; log_d.delete(); log_a.delete(); fill_seq(132);
    start_dl(8'd3); send(0, 131, 0, 0); repeat (3) tick();
    chk("t5_ovf", overflow, 1); chk("t5_wait", ioctl_wait, 1);
    end_dl(); req_mode = 1; wait_idle();
    chk("t5_nwords", log_d.size(), 64); chk("t5_w0", logd(0), 16'h0100);
    chk("t5_w63", logd(63), 16'h7F7E); chk("t5_loaded", loaded, 4'b1011);
    chk("t5_ovf_sticky", overflow, 1);

    // invalid index is ignored
    fill_seq(10);
    start_dl(8'd9); send(0, 9, 1, 0); end_dl(); repeat (3) tick();
    chk("t6_busy", busy, 0); chk("t6_ld_wr", ld_wr, 0); chk("t6_loaded", loaded, 4'b1011);

    // asynchronous reset in the middle of a fill
    req_mode = 0; fill_seq(20);
    start_dl(8'd1); send(0, 19, 1, 0); tick();
    reset_n = 1'b0; ioctl_download = 1'b0; #1;
    chk("t7_busy", busy, 0); chk("t7_loaded", loaded, 0); chk("t7_ld_target", ld_target, 0);
    chk("t7_ld_din", ld_din, 0); chk("t7_ld_addr", ld_addr, 0);
    tick(); reset_n = 1'b1; tick();
    req_mode = 1; log_d.delete(); log_a.delete(); fill_seq(16);
    start_dl(8'd2); send(0, 15, 1, 0); end_dl(); wait_idle();
    chk("t7_a0", loga(0), 0); chk("t7_nwords", log_d.size(), 8);
    chk("t7_loaded", loaded, 4'b0100);

    // random downloads, random consumer, back-to-back re-triggers
    req_mode = 2;
    for (int k = 0; k < 25; k++) begin
      n = (k == 3) ? 0 : int'($urandom_range(1, 150));
      bbuf.delete();
      for (int i = 0; i < n; i++) bbuf.push_back(8'($urandom));
      start_dl(8'($urandom_range(0, 5)));
      if (n > 0) send(0, n-1, 1, 2);
      end_dl();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
